// File: rtl/ni_req_scheduler.sv
// ---------------------------------------------------------------------------
// ni_req_scheduler
//
// Request-side scheduler for the NI initiator. Two packet sources share the
// single request flit path into out_buffer:
//   - the write-packet builder (AW+W), port prefix wr_
//   - the read-packet builder (AR),    port prefix rd_
//
// Packets are kept atomic on the link: once a multi-flit packet's head has
// been transferred, that source keeps the output until its tail goes out.
// Head selection alternates fairly between the sources. The number of
// outstanding write and read transactions is capped using the decrement
// pulses coming back from the response side.
//
// The data path is purely combinational. No flit is stored here, and every
// transfer is a valid && ready handshake on the source side.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   wr_valid/flit/last    write source flit, plus its tail marker
//   wr_ready              write flit consumed this cycle
//   rd_valid/flit/last    read source flit, plus its tail marker
//   rd_ready              read flit consumed this cycle
//   flit_out, valid_out   flit and write strobe towards out_buffer
//   stall_in              out_buffer is full
//   decr_wr, decr_rd      one write / read response completed (1-cycle pulse)
//   outs_wr, outs_rd      current outstanding write / read counts
//   err_underflow         sticky flag: a decrement arrived with its count at 0
// ---------------------------------------------------------------------------
module ni_req_scheduler #(
  parameter int FLIT_WIDTH  = 80,
  parameter int MAX_OUTS_WR = 8,
  parameter int MAX_OUTS_RD = 8,
  parameter int CNT_WD      = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  wr_valid,
  input  logic [FLIT_WIDTH-1:0] wr_flit,
  input  logic                  wr_last,
  output logic                  wr_ready,

  input  logic                  rd_valid,
  input  logic [FLIT_WIDTH-1:0] rd_flit,
  input  logic                  rd_last,
  output logic                  rd_ready,

  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  valid_out,
  input  logic                  stall_in,

  input  logic                  decr_wr,
  input  logic                  decr_rd,
  output logic [CNT_WD-1:0]     outs_wr,
  output logic [CNT_WD-1:0]     outs_rd,
  output logic                  err_underflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_PKT = 2'd1,
    RD_PKT = 2'd2
  } state_t;

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_t;

  localparam logic [CNT_WD-1:0] MAX_WR_C = CNT_WD'(MAX_OUTS_WR);
  localparam logic [CNT_WD-1:0] MAX_RD_C = CNT_WD'(MAX_OUTS_RD);
  localparam logic [CNT_WD-1:0] CNT_ONE  = CNT_WD'(1);

  state_t            state_q, state_d;
  prio_t             prio_q, prio_d;
  logic [CNT_WD-1:0] outs_wr_q, outs_wr_d;
  logic [CNT_WD-1:0] outs_rd_q, outs_rd_d;
  logic              err_underflow_q, err_underflow_d;

  logic wr_below, rd_below;
  logic wr_elig, rd_elig;
  logic wr_xfer, rd_xfer;
  logic inc_wr, inc_rd;

  // A source may start a new transaction only when its outstanding count
  // is below the cap. Body flits of a packet that is already running are
  // not affected by this.
  always_comb begin
    wr_below = (outs_wr_q < MAX_WR_C);
    rd_below = (outs_rd_q < MAX_RD_C);
    wr_elig  = wr_valid && wr_below;
    rd_elig  = rd_valid && rd_below;
  end

  // Output mux and ready generation.
  // In IDLE, a source's ready means "you would win the head slot if you
  // were valid". This keeps each ready free of the same source's valid.
  // It only looks at the registers, stall_in and the other source's
  // eligibility. Both readies can never be granted to two valid, eligible
  // sources at once, because the prio term breaks the tie.
  // While locked, only the owning source reaches the output. Its bubbles
  // show up as valid_out=0 without releasing the lock.
  always_comb begin
    wr_ready  = 1'b0;
    rd_ready  = 1'b0;
    valid_out = 1'b0;
    flit_out  = '0;
    unique case (state_q)
      IDLE: begin
        wr_ready = !stall_in && wr_below && ((prio_q == PRIO_WR) || !rd_elig);
        rd_ready = !stall_in && rd_below && ((prio_q == PRIO_RD) || !wr_elig);
        if (wr_elig && ((prio_q == PRIO_WR) || !rd_elig)) begin
          valid_out = 1'b1;
          flit_out  = wr_flit;
        end else if (rd_elig) begin
          valid_out = 1'b1;
          flit_out  = rd_flit;
        end
      end
      WR_PKT: begin
        wr_ready  = !stall_in;
        valid_out = wr_valid;
        flit_out  = wr_flit;
      end
      RD_PKT: begin
        rd_ready  = !stall_in;
        valid_out = rd_valid;
        flit_out  = rd_flit;
      end
      default: begin
      end
    endcase
    // Nothing may be accepted or emitted while reset is held, even if the
    // registers still show a packet in flight.
    if (rst) begin
      wr_ready  = 1'b0;
      rd_ready  = 1'b0;
      valid_out = 1'b0;
    end
  end

  // Next-state logic. A head transfer in IDLE commits a transaction, which
  // bumps the counter. A single-flit packet hands priority straight to the
  // other source. A multi-flit head locks the path until the tail goes out.
  always_comb begin
    wr_xfer = wr_valid && wr_ready;
    rd_xfer = rd_valid && rd_ready;
    state_d = state_q;
    prio_d  = prio_q;
    inc_wr  = 1'b0;
    inc_rd  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_xfer) begin
          inc_wr = 1'b1;
          if (wr_last) begin
            prio_d = PRIO_RD;
          end else begin
            state_d = WR_PKT;
          end
        end else if (rd_xfer) begin
          inc_rd = 1'b1;
          if (rd_last) begin
            prio_d = PRIO_WR;
          end else begin
            state_d = RD_PKT;
          end
        end
      end
      WR_PKT: begin
        if (wr_xfer && wr_last) begin
          state_d = IDLE;
          prio_d  = PRIO_RD;
        end
      end
      RD_PKT: begin
        if (rd_xfer && rd_last) begin
          state_d = IDLE;
          prio_d  = PRIO_WR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outstanding counters. When an increment and a decrement land in the
  // same cycle they cancel out. A decrement that would wrap below zero is
  // dropped and recorded in the sticky error flag instead. Overflow is
  // impossible because eligibility stops heads at the cap.
  always_comb begin
    outs_wr_d       = outs_wr_q;
    outs_rd_d       = outs_rd_q;
    err_underflow_d = err_underflow_q;

    if (inc_wr && !decr_wr) begin
      outs_wr_d = outs_wr_q + CNT_ONE;
    end else if (!inc_wr && decr_wr) begin
      if (outs_wr_q == '0) begin
        err_underflow_d = 1'b1;
      end else begin
        outs_wr_d = outs_wr_q - CNT_ONE;
      end
    end

    if (inc_rd && !decr_rd) begin
      outs_rd_d = outs_rd_q + CNT_ONE;
    end else if (!inc_rd && decr_rd) begin
      if (outs_rd_q == '0) begin
        err_underflow_d = 1'b1;
      end else begin
        outs_rd_d = outs_rd_q - CNT_ONE;
      end
    end
  end

  // State, priority, counters and the error flag. A reset mid-packet simply
  // abandons the partial packet; the sources are reset alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      prio_q          <= PRIO_WR;
      outs_wr_q       <= '0;
      outs_rd_q       <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      prio_q          <= prio_d;
      outs_wr_q       <= outs_wr_d;
      outs_rd_q       <= outs_rd_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign outs_wr       = outs_wr_q;
  assign outs_rd       = outs_rd_q;
  assign err_underflow = err_underflow_q;

endmodule
